// File: rtl/ascon_params.sv
// rtl/ascon_params.sv - shared Ascon datapath constants, unmasker beat geometry and state type
package ascon_params;

  localparam int ASCON_WORD_SIZE  = 64;
  localparam int ASCON_PAR        = 6;
  localparam int ASCON_NUM_SHARES = 11;

  function automatic int unmask_beats(input int word_size, input int par);
    return (word_size + par - 1) / par;
  endfunction

  function automatic int unmask_last_bits(input int word_size, input int par);
    return (word_size % par == 0) ? par : word_size % par;
  endfunction

  localparam int SHIFT_PAR_LAST   = unmask_last_bits(ASCON_WORD_SIZE, ASCON_PAR);
  localparam int UNMASK_BEATS     = unmask_beats(ASCON_WORD_SIZE, ASCON_PAR);
  localparam int UNMASK_LAST_BITS = SHIFT_PAR_LAST;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } unmask_state_t;

endpackage

// File: rtl/ascon_share_unmasker_if.sv
// rtl/ascon_share_unmasker_if.sv - share-beat input stream and unmasked-word output handshake
interface ascon_share_unmasker_if #(
  parameter int WORD_SIZE  = 64,
  parameter int PAR        = 6,
  parameter int NUM_SHARES = 11
);
  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_SHARES*PAR-1:0]  in_shares;
  logic                       out_valid;
  logic                       out_ready;
  logic [WORD_SIZE-1:0]       out_word;
  logic                       busy;

  modport master (
    output in_valid, in_shares, out_ready,
    input  in_ready, out_valid, out_word, busy
  );

  modport slave (
    input  in_valid, in_shares, out_ready,
    output in_ready, out_valid, out_word, busy
  );
endinterface

// File: rtl/ascon_share_xor.sv
// rtl/ascon_share_xor.sv - PAR-bit XOR reduction across NUM_SHARES Boolean shares
module ascon_share_xor #(
  parameter int PAR        = 6,
  parameter int NUM_SHARES = 11
) (
  input  logic [NUM_SHARES*PAR-1:0] shares,
  output logic [PAR-1:0]            r
);

  always_comb begin
    r = '0;
    for (int s = 0; s < NUM_SHARES; s++) begin
      r = r ^ shares[s*PAR +: PAR];
    end
  end

endmodule

// File: rtl/ascon_share_unmasker.sv
// rtl/ascon_share_unmasker.sv - recombines streamed Boolean shares into an unmasked word
// Optional ASCON_UNMASK_CLEAR_EN: clear word register on handshake and gate out_word outside HOLD.
module ascon_share_unmasker
  import ascon_params::*;
#(
  parameter int WORD_SIZE  = 64,
  parameter int PAR        = 6,
  parameter int NUM_SHARES = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ascon_share_unmasker_if.slave  bus
);

  localparam int BEATS = unmask_beats(WORD_SIZE, PAR);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  logic [1:0]           rst_sync;
  logic                 rst_int_n;
  unmask_state_t        state;
  unmask_state_t        state_next;
  logic [CNT_W-1:0]     cnt;
  logic [WORD_SIZE-1:0] word_q;
  logic [PAR-1:0]       beat_r;
  logic                 accept;
  logic                 handshake;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  ascon_share_xor #(.PAR(PAR), .NUM_SHARES(NUM_SHARES)) u_xor (
    .shares (bus.in_shares),
    .r      (beat_r)
  );

  assign accept    = bus.in_valid  && (state == COLLECT);
  assign handshake = bus.out_ready && (state == HOLD);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= COLLECT;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (accept && cnt == CNT_LAST) state_next = HOLD;
      HOLD:    if (handshake)                 state_next = COLLECT;
      default:                                state_next = COLLECT;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == COLLECT);
    bus.out_valid = (state == HOLD);
    bus.busy      = ((state == COLLECT) && (cnt != '0)) || (state == HOLD);
  end

  // Bits past the word boundary on the last beat have no slot and are dropped.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cnt    <= '0;
      word_q <= '0;
    end else if (accept) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      for (int i = 0; i < WORD_SIZE; i++) begin
        if (i / PAR == int'(cnt)) word_q[i] <= beat_r[i % PAR];
      end
    end
`ifdef ASCON_UNMASK_CLEAR_EN
    else if (handshake) begin
      word_q <= '0;
    end
`endif
  end

`ifdef ASCON_UNMASK_CLEAR_EN
  assign bus.out_word = (state == HOLD) ? word_q : '0;
`else
  assign bus.out_word = word_q;
`endif

endmodule

// File: tb/tb_ascon_share_unmasker.sv
// tb/tb_ascon_share_unmasker.sv - randomized self-checking bench for ascon_share_unmasker
module tb_ascon_share_unmasker;
  localparam int WORD_SIZE  = 64;
  localparam int PAR        = 6;
  localparam int NUM_SHARES = 11;
  localparam int BEATS      = (WORD_SIZE + PAR - 1) / PAR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ascon_share_unmasker_if #(.WORD_SIZE(WORD_SIZE), .PAR(PAR), .NUM_SHARES(NUM_SHARES)) bus ();

  ascon_share_unmasker #(.WORD_SIZE(WORD_SIZE), .PAR(PAR), .NUM_SHARES(NUM_SHARES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [WORD_SIZE-1:0] sh [NUM_SHARES];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [WORD_SIZE-1:0] golden();
    logic [WORD_SIZE-1:0] g = '0;
    for (int s = 0; s < NUM_SHARES; s++) g = g ^ sh[s];
    return g;
  endfunction

  // Beat k takes word bits [k*PAR +: PAR] of every share; slots beyond the word get filler.
  function automatic logic [NUM_SHARES*PAR-1:0] make_beat(input int k, input bit junk);
    logic [NUM_SHARES*PAR-1:0] b;
    for (int s = 0; s < NUM_SHARES; s++) begin
      for (int j = 0; j < PAR; j++) begin
        int idx = k * PAR + j;
        if (idx < WORD_SIZE) b[s*PAR + j] = sh[s][idx];
        else                 b[s*PAR + j] = junk ? 1'b1 : 1'($urandom_range(1, 0));
      end
    end
    return b;
  endfunction

  task automatic fill_random();
    for (int s = 0; s < NUM_SHARES; s++) sh[s] = rand64();
  endtask

  task automatic run_word(input logic [63:0] exp, input bit junk, input bit gaps,
                          input int hold, input bit measure);
    int edges = 0;
    for (int k = 0; k < BEATS; k++) begin
      if (gaps && k > 0) begin
        repeat ($urandom_range(2, 0)) begin
          bus.in_valid = 1'b0;
          @(negedge clk);
          edges++;
          check("busy_gap", bus.busy, 1);
        end
      end
      check("in_ready", bus.in_ready, 1);
      check("early_valid", bus.out_valid, 0);
      bus.in_valid  = 1'b1;
      bus.in_shares = make_beat(k, junk);
      @(negedge clk);
      edges++;
    end
    bus.in_valid  = (hold > 0);
    bus.in_shares = {$urandom, $urandom, $urandom};
    check("out_valid", bus.out_valid, 1);
    if (measure) check("latency", edges, BEATS);
    check("out_word", bus.out_word, exp);
    check("in_ready_hold", bus.in_ready, 0);
    check("busy_hold", bus.busy, 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_word", bus.out_word, exp);
      check("hold_valid", bus.out_valid, 1);
      check("hold_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_valid", bus.out_valid, 0);
    check("post_busy", bus.busy, 0);
    check("post_ready", bus.in_ready, 1);
`ifdef ASCON_UNMASK_CLEAR_EN
    check("post_word", bus.out_word, 0);
`else
    check("post_word", bus.out_word, exp);
`endif
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_shares = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.out_valid, 0);
    check("rst_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_word", bus.out_word, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int s = 0; s < NUM_SHARES; s++) sh[s] = '0;
    sh[0] = 64'h0123456789ABCDEF;
    run_word(64'h0123456789ABCDEF, 1'b0, 1'b0, 0, 1'b1);

    fill_random();
    sh[NUM_SHARES-1] = '0;
    sh[NUM_SHARES-1] = golden() ^ 64'hDEADBEEFCAFEF00D;
    run_word(64'hDEADBEEFCAFEF00D, 1'b0, 1'b0, 0, 1'b1);

    fill_random();
    run_word(golden(), 1'b0, 1'b0, 5, 1'b1);
    fill_random();
    run_word(golden(), 1'b0, 1'b1, 0, 1'b0);

    fill_random();
    sh[NUM_SHARES-1] = '0;
    sh[NUM_SHARES-1] = golden() ^ 64'h0FEDCBA987654321;
    run_word(64'h0FEDCBA987654321, 1'b1, 1'b0, 0, 1'b1);

    fill_random();
    for (int k = 0; k < 6; k++) begin
      bus.in_valid  = 1'b1;
      bus.in_shares = make_beat(k, 1'b0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("mid_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_word", bus.out_word, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    fill_random();
    run_word(golden(), 1'b0, 1'b0, 0, 1'b1);

    for (int n = 0; n < 20; n++) begin
      fill_random();
      run_word(golden(), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
               int'($urandom_range(3, 0)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascon_share_unmasker.md
# ascon_share_unmasker

Receive-side recombiner for the masked Ascon datapath. It accepts a 64-bit word as `NUM_SHARES` Boolean shares streamed `PAR` bits per share per beat, XOR-recombines each beat, and assembles the unmasked word. It sits at the output of the masked permutation/serializer, where ciphertext and tag leave the share domain. It is the inverse of the share-splitting input path that consumes LFSR randomness.

## Interface
- `WORD_SIZE`, default 64: width of the recombined word.
- `PAR`, default 6: bits per share per beat.
- `NUM_SHARES`, default 11 (d+1): number of shares.
- `clk` input, 1 bit: single clock.
- `rst_n` input, 1 bit: reset. Asynchronous, active-low.
- `in_valid` input, 1 bit: the beat on `in_shares` is valid.
- `in_ready` output, 1 bit: the block accepts a beat.
- `in_shares` input, NUM_SHARES*PAR bits: share s occupies `[s*PAR +: PAR]`.
- `out_valid` output, 1 bit: `out_word` holds a complete recombined word.
- `out_ready` input, 1 bit: the consumer takes the word.
- `out_word` output, WORD_SIZE bits: unmasked word.
- `busy` output, 1 bit: at least one beat of the current word has been accepted.

## Operation
- BEATS = ceil(WORD_SIZE/PAR), which is 11 at defaults. LAST_BITS = WORD_SIZE mod PAR, or PAR if that is 0. At defaults LAST_BITS is 4.
- Beat k carries word bits `[k*PAR +: PAR]` of every share, LSB first.
- On the last beat, only the low LAST_BITS of each share slice are used. The upper bits are ignored.
- Per accepted beat: r = XOR over s of the share-s slice. r is written to word bits `[k*PAR +: PAR]`, truncated to the word boundary.
- Beat counter `cnt` has width clog2(BEATS) and ranges 0..BEATS-1. It never wraps past BEATS-1.
- FSM states:
  - COLLECT: `in_ready`=1. On `in_valid`, store the beat and increment `cnt`. If `cnt`==BEATS-1, go to HOLD and clear `cnt` to 0.
  - HOLD: `in_ready`=0 and `out_valid`=1. On `out_ready`, go to COLLECT.
- `busy` = (state==COLLECT && cnt!=0) || state==HOLD.
- `in_valid` is ignored while in HOLD. The upstream must hold its beat until it sees `in_ready`.
- An output handshake and an input beat never share a cycle, because `in_ready`=0 in HOLD.
- The unmasked word must never be fed back into any share path.

## Timing
- Reset (asynchronous assert, synchronous deassert by the top):
  - state = COLLECT, `cnt` = 0, word register = 0.
  - `out_valid`=0, `in_ready`=1, `busy`=0, `out_word`=0.
- Latency: `out_valid` rises the cycle after the final beat is accepted.
- Throughput: one word per BEATS+1 cycles at full rate, which is 12 cycles at defaults.
- `out_word` is registered and stable throughout HOLD, regardless of `out_ready`.
- If reset arrives mid-word, the partial word is discarded. The next word starts again at beat 0.
- `in_ready` and `out_valid` are decoded from the registered state only. There is no combinational path from `in_valid` or `out_ready`.

## Configuration
- `ASCON_UNMASK_CLEAR_EN` defined:
  - The word register is zeroed in the cycle the output handshake completes.
  - `out_word` is gated to 0 whenever `out_valid`=0.
  - This prevents unmasked residue lingering on the bus.
- `ASCON_UNMASK_CLEAR_EN` undefined:
  - The word register is not cleared.
  - `out_word` shows the register contents at all times. After a handshake it keeps the last word until beats overwrite it.

## Structure
- Shared package `ascon_params` gains:
  - `UNMASK_BEATS` and `UNMASK_LAST_BITS`, derived from `PAR` and `WORD_SIZE`. These are consistent with `SHIFT_PAR_LAST`.
  - typedef enum `unmask_state_t {COLLECT, HOLD}`.
- One combinational sub-module, `ascon_share_xor`: parameterised PAR×NUM_SHARES XOR reduction, reused wherever shares are recombined.

## Test plan
- Share 0 = 0x0123456789ABCDEF, all other shares 0, 11 back-to-back beats -> `out_valid` at cycle 12 with `out_word`=0x0123456789ABCDEF.
- Ten random shares plus an eleventh chosen so the XOR = 0xDEADBEEFCAFEF00D -> `out_word`=0xDEADBEEFCAFEF00D.
- Hold `out_ready`=0 for 5 cycles in HOLD -> `out_word` stable, `in_ready`=0, extra `in_valid` beats not consumed. The next word after release is correct.
- Last-beat share bits [5:4] forced to 1 in every share -> `out_word[63:60]` unaffected. Result equals the golden word.
- Assert `rst_n` after beat 5 -> `out_valid`=0, `busy`=0, `out_word`=0 immediately. A following full word recombines correctly.
- With `ASCON_UNMASK_CLEAR_EN`: after a handshake `out_word`=0 at the next cycle. Without it: `out_word` keeps the previous value.
